pll_lock_reset_seq: RTL



---
 rtl/pll_lock_reset_seq_pkg.sv | 26 ++
 rtl/pll_lock_reset_seq_sync_2ff.sv | 24 ++
 rtl/pll_lock_reset_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock / reset sequencer.
// Pure declarations: no latency, no flow control.
package pll_lock_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter only ever reaches (limit-1), so clog2 of the largest limit suffices.
  function automatic int cnt_width(input int a, input int b, input int c);
    int w;
    w = $clog2(max3(a, b, c));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync_2ff.sv
// Two-flop synchronizer for level-stable asynchronous inputs, reset to 0.
// Latency: 2 clk edges; no backpressure.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Drives PLL RESET from its LOCK, releasing sys_rst_n once lock is stable; retries, then faults.
// Latency: release STABLE_CYCLES+2 edges after lock sampled, drop 3 edges; no backpressure.
module pll_lock_reset_seq
  import pll_lock_reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 270000,
  parameter int STABLE_CYCLES  = 2700,
  parameter int MAX_RETRIES    = 3,
  parameter int LOL_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             sys_rst_n,
  output logic             locked_ok,
  output logic             fault,
  output logic [7:0]       retry_cnt,
  output logic [LOL_W-1:0] lol_cnt
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

  logic             lock_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_d;
  logic [LOL_W-1:0] lol_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    lol_d   = lol_cnt;
    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_PLL_RST;
            retry_d = retry_cnt + 8'd1;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s)                   state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          if (lol_cnt != '1) lol_d = lol_cnt + 1'b1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_PLL_RST;
    endcase

    if (state_d == ST_RUN && state_q != ST_RUN) retry_d = 8'd0;

    // Counter is only meaningful in the timed states; it idles at 0 in RUN/FAULT.
    if (state_d != state_q || state_d == ST_RUN || state_d == ST_FAULT) cnt_d = '0;
    else                                                                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      retry_cnt <= 8'd0;
      lol_cnt   <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      locked_ok <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      lol_cnt   <= lol_d;
      pll_reset <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
      sys_rst_n <= (state_d == ST_RUN);
      locked_ok <= (state_d == ST_RUN);
      fault     <= (state_d == ST_FAULT);
    end
  end

endmodule
